viterbi_txrx_2b4: RTL and testbench



---
 rtl/viterbi_2b4_pkg.sv | 33 +++
 rtl/viterbi_acs_2b4.sv | 33 +++
 rtl/viterbi_txrx_2b4.sv | 176 +++++++++++++++++
 tb/tb_viterbi_txrx_2b4.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/viterbi_2b4_pkg.sv
// Shared constants, types and helpers for the K=3 rate-1/2 Viterbi link.
// The LFSR constants are only used when ERR_INJ_EN is defined.
package viterbi_2b4_pkg;

    localparam logic [2:0]  G0         = 3'b111;
    localparam logic [2:0]  G1         = 3'b101;
    localparam int          NUM_STATES = 4;
    localparam int          METRIC_W   = 6;
    localparam int          RENORM_TH  = 32;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam int          ERR_PERIOD = 16;

    typedef logic [1:0]          sym_t;
    typedef logic [METRIC_W-1:0] metric_t;

    localparam metric_t METRIC_MAX = '1;

    // Code symbol {c0,c1} for input bit b leaving state st = {b[n-1], b[n-2]}.
    function automatic sym_t enc_sym(input logic b, input logic [1:0] st);
        logic [2:0] win;
        win = {b, st};
        return {^(win & G0), ^(win & G1)};
    endfunction

    // Hamming distance between two symbols (0..2).
    function automatic logic [1:0] hamming(input sym_t a, input sym_t b);
        sym_t d;
        d = a ^ b;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_2b4.sv
// One add-compare-select unit: saturating adds of two candidate paths,
// keeps the smaller one; a tie keeps the lower-numbered predecessor (dec=0).
module viterbi_acs_2b4
    import viterbi_2b4_pkg::*;
(
    input  metric_t    pm0,
    input  logic [1:0] bm0,
    input  metric_t    pm1,
    input  logic [1:0] bm1,
    output metric_t    pm_new,
    output logic       dec
);

    logic [METRIC_W:0] sum0;
    logic [METRIC_W:0] sum1;
    metric_t           sat0;
    metric_t           sat1;

    // Add with saturation at the metric ceiling, then select the survivor.
    always_comb begin
        sum0   = {1'b0, pm0} + (METRIC_W+1)'(bm0);
        sum1   = {1'b0, pm1} + (METRIC_W+1)'(bm1);
        sat0   = sum0[METRIC_W] ? METRIC_MAX : sum0[METRIC_W-1:0];
        sat1   = sum1[METRIC_W] ? METRIC_MAX : sum1[METRIC_W-1:0];
        pm_new = sat0;
        dec    = 1'b0;
        if (sat1 < sat0) begin
            pm_new = sat1;
            dec    = 1'b1;
        end
    end

endmodule

// File: rtl/viterbi_txrx_2b4.sv
// K=3 rate-1/2 encoder -> error-injecting channel -> 4-state register-exchange
// Viterbi decoder -> alignment delay line. Optional macro ERR_INJ_EN enables
// the LFSR-driven single-bit error injection; without it the channel is clean.
// Pipeline: sym_p0 (encode), rx_p1 (channel), TB_DEPTH survivor steps,
// dec_p2 (decision), DL-bit delay line, decoder_o => LATENCY register stages.
module viterbi_txrx_2b4
    import viterbi_2b4_pkg::*;
#(
    parameter int LATENCY  = 4105,
    parameter int TB_DEPTH = 32
)
(
    input  logic clk,
    input  logic rst,
    input  logic encoder_i,
    input  logic enable_encoder_i,
    output logic decoder_o
);

    localparam int DL = LATENCY - TB_DEPTH - 4;

    logic [1:0]          enc_st;
    sym_t                sym_p0;
    sym_t                rx_p1;
    logic [1:0]          err_inj;
    logic [31:0]         word_ct;
    logic [31:0]         error_counter;

    metric_t             pm       [NUM_STATES];
    metric_t             pm_acs   [NUM_STATES];
    metric_t             pm_next  [NUM_STATES];
    logic                dec_acs  [NUM_STATES];
    logic [TB_DEPTH-1:0] surv     [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_next[NUM_STATES];
    logic                all_hi;
    logic [1:0]          best;
    metric_t             best_pm;
    logic                dec_p2;
    logic [DL-1:0]       dly;

    // Encoder stage: shift register, registered code symbol and word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_st  <= '0;
            sym_p0  <= '0;
            word_ct <= '0;
        end else if (enable_encoder_i) begin
            sym_p0  <= enc_sym(encoder_i, enc_st);
            enc_st  <= {encoder_i, enc_st[1]};
            word_ct <= word_ct + 32'd1;
        end
    end

`ifdef ERR_INJ_EN
    localparam int GAP_W = $clog2(ERR_PERIOD + 1);

    logic [15:0]      lfsr;
    logic [GAP_W-1:0] gap;
    logic [1:0]       mask;

    // Error mask: one flipped bit when the LFSR low nibble is zero and enough pairs have passed.
    always_comb begin
        mask = 2'b00;
        if (lfsr[3:0] == 4'd0 && gap >= GAP_W'(ERR_PERIOD))
            mask = lfsr[4] ? 2'b10 : 2'b01;
    end

    // Channel stage: advance LFSR, apply mask, track spacing and error count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr          <= LFSR_SEED;
            gap           <= '0;
            err_inj       <= '0;
            error_counter <= '0;
            rx_p1         <= '0;
        end else if (enable_encoder_i) begin
            lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            err_inj <= mask;
            rx_p1   <= sym_p0 ^ mask;
            if (mask != 2'b00) begin
                error_counter <= error_counter + 32'd1;
                gap           <= '0;
            end else if (gap < GAP_W'(ERR_PERIOD)) begin
                gap <= gap + 1'b1;
            end
        end
    end
`else
    assign err_inj       = 2'b00;
    assign error_counter = 32'd0;

    // Channel stage: clean pass-through register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rx_p1 <= '0;
        else if (enable_encoder_i)
            rx_p1 <= sym_p0;
    end
`endif

    // Trellis: next state j={b,b1} is reached from {j[0],0} or {j[0],1} with input b=j[1].
    for (genvar j = 0; j < NUM_STATES; j++) begin : g_acs
        localparam logic [1:0] ST = 2'(j);
        localparam logic [1:0] P0 = {ST[0], 1'b0};
        localparam logic [1:0] P1 = {ST[0], 1'b1};

        logic [1:0] bm0;
        logic [1:0] bm1;

        assign bm0 = hamming(rx_p1, enc_sym(ST[1], P0));
        assign bm1 = hamming(rx_p1, enc_sym(ST[1], P1));

        viterbi_acs_2b4 u_acs (
            .pm0    (pm[P0]),
            .bm0    (bm0),
            .pm1    (pm[P1]),
            .bm1    (bm1),
            .pm_new (pm_acs[j]),
            .dec    (dec_acs[j])
        );

        assign surv_next[j] = {(dec_acs[j] ? surv[P1][TB_DEPTH-2:0]
                                           : surv[P0][TB_DEPTH-2:0]), ST[1]};
    end

    // Renormalise: when every metric has reached the threshold, pull them all down.
    always_comb begin
        all_hi = 1'b1;
        for (int i = 0; i < NUM_STATES; i++)
            if (pm_acs[i] < metric_t'(RENORM_TH))
                all_hi = 1'b0;
        for (int i = 0; i < NUM_STATES; i++)
            pm_next[i] = all_hi ? (pm_acs[i] - metric_t'(RENORM_TH)) : pm_acs[i];
    end

    // Best state: smallest current metric, lowest index on ties.
    always_comb begin
        best    = 2'd0;
        best_pm = pm[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm[i] < best_pm) begin
                best_pm = pm[i];
                best    = 2'(i);
            end
        end
    end

    // Survivor stage: metrics, register-exchange paths and the decided bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i]   <= (i == 0) ? metric_t'(0) : METRIC_MAX;
                surv[i] <= '0;
            end
            dec_p2 <= 1'b0;
        end else if (enable_encoder_i) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i]   <= pm_next[i];
                surv[i] <= surv_next[i];
            end
            dec_p2 <= surv[best][TB_DEPTH-1];
        end
    end

    // Alignment stage: delay line padding the path to exactly LATENCY edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly       <= '0;
            decoder_o <= 1'b0;
        end else if (enable_encoder_i) begin
            dly       <= {dly[DL-2:0], dec_p2};
            decoder_o <= dly[DL-1];
        end
    end

endmodule

// File: tb/tb_viterbi_txrx_2b4.sv
// Link bench: encoder vector table, then pattern/random/long-run streams with
// a latency reference model (decoded bit = source bit LATENCY edges earlier),
// a mid-stream reset, and error-injection checks depending on ERR_INJ_EN.
module tb_viterbi_txrx_2b4;

    localparam int LATENCY = 4105;

    typedef struct {
        logic       b;
        logic [1:0] sym;
    } enc_vec_t;

    logic clk = 1'b0;
    logic rst;
    logic encoder_i;
    logic enable_encoder_i;
    logic decoder_o;

    int checks   = 0;
    int failures = 0;

    bit src_q[$];

    viterbi_txrx_2b4 dut (
        .clk              (clk),
        .rst              (rst),
        .encoder_i        (encoder_i),
        .enable_encoder_i (enable_encoder_i),
        .decoder_o        (decoder_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: output after the latest edge is the source bit LATENCY-1 enabled edges back.
    function automatic logic exp_out();
        int idx;
        idx = src_q.size() - LATENCY;
        if (idx < 0)
            return 1'b0;
        return src_q[idx];
    endfunction

    task automatic step(input logic b, input logic en, input logic r);
        @(negedge clk);
        encoder_i        = b;
        enable_encoder_i = en;
        rst              = r;
        @(posedge clk);
        if (r && en)
            src_q.push_back(b);
        #1;
        check_val("decoder_o", {31'd0, decoder_o}, {31'd0, exp_out()});
        check_val("word_ct", dut.word_ct, 32'(src_q.size()));
`ifdef ERR_INJ_EN
        check_val("err_inj_single_bit", {31'd0, ($countones(dut.err_inj) <= 1)}, 32'd1);
`else
        check_val("err_inj_zero", {30'd0, dut.err_inj}, 32'd0);
        check_val("error_counter_zero", dut.error_counter, 32'd0);
`endif
    endtask

    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++)
            step(b, 1'b1, 1'b1);
    endtask

    task automatic run_random(input int n, input bit rand_en);
        for (int i = 0; i < n; i++)
            step(1'($urandom_range(0, 1)),
                 rand_en ? 1'($urandom_range(0, 3) != 0) : 1'b1, 1'b1);
    endtask

    enc_vec_t enc_tbl[8];
    bit       pat[$];

    initial begin
        // Encoder from the all-zero state: {c0,c1} = {b^b1^b2, b^b2}.
        enc_tbl[0] = '{1'b1, 2'b11};
        enc_tbl[1] = '{1'b0, 2'b10};
        enc_tbl[2] = '{1'b1, 2'b00};
        enc_tbl[3] = '{1'b1, 2'b01};
        enc_tbl[4] = '{1'b1, 2'b10};
        enc_tbl[5] = '{1'b0, 2'b01};
        enc_tbl[6] = '{1'b0, 2'b11};
        enc_tbl[7] = '{1'b0, 2'b00};

        for (int r = 1; r <= 5; r++) begin
            for (int k = 0; k < r; k++) pat.push_back(1'b1);
            for (int k = 0; k < r; k++) pat.push_back(1'b0);
        end
        while (pat.size() < 128)
            pat.push_back((pat.size() % 2) == 0);

        rst              = 1'b0;
        encoder_i        = 1'b0;
        enable_encoder_i = 1'b1;

        // Reset held for 10 edges: output and counters stay at zero.
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 1'b0);

        // Encoder symbol table right after release.
        for (int i = 0; i < 8; i++) begin
            step(enc_tbl[i].b, 1'b1, 1'b1);
            check_val("enc_sym", {30'd0, dut.sym_p0}, {30'd0, enc_tbl[i].sym});
        end

        // Run-length pattern, twice.
        for (int rep = 0; rep < 2; rep++)
            foreach (pat[i])
                step(pat[i], 1'b1, 1'b1);

        // Random bits framed by runs, then random bits with random holds.
        run(1'b1, 10);
        run_random(20, 1'b0);
        run(1'b0, 10);
        run_random(200, 1'b1);

        // Long runs of ones.
        for (int rep = 0; rep < 3; rep++) begin
            run(1'b1, 100);
            run(1'b0, 20);
        end

        // Flush so every source bit above reaches the output.
        run(1'b0, LATENCY + 5);
`ifdef ERR_INJ_EN
        check_val("error_counter_nonzero", {31'd0, (dut.error_counter != 32'd0)}, 32'd1);
`else
        check_val("error_counter_zero_end", dut.error_counter, 32'd0);
`endif

        // Mid-stream reset: asynchronous clear takes effect before the next edge.
        run_random(50, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        src_q.delete();
        #1;
        check_val("midrst_decoder_o", {31'd0, decoder_o}, 32'd0);
        check_val("midrst_word_ct", dut.word_ct, 32'd0);
        check_val("midrst_error_counter", dut.error_counter, 32'd0);
        check_val("midrst_err_inj", {30'd0, dut.err_inj}, 32'd0);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 1'b0);

        // Post-release data decodes at LATENCY.
        run(1'b1, 5);
        run_random(60, 1'b0);
        run(1'b0, LATENCY + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
